// File: rtl/exec_sequencer_if.sv
// Handshake and decoder-control bundle between the instruction pipeline,
// the multiplier, the external I/O ports and the execution sequencer.
interface exec_sequencer_if;
    logic [5:0] opcode;
    logic [2:0] alu_func;
    logic       reg_write_dec;
    logic       pc_rel_branch_dec;
    logic       read_in_dec;
    logic       write_out_dec;
    logic       mul_done;
    logic       in_valid;
    logic       out_ready;

    logic       pc_en;
    logic       reg_write;
    logic       pc_rel_branch;
    logic       mul_start;
    logic       in_ack;
    logic       out_valid;
    logic       busy;
    logic       err;

    // Sequencer side: consumes decoder/handshake inputs, drives qualified controls.
    modport master (
        input  opcode, alu_func, reg_write_dec, pc_rel_branch_dec,
               read_in_dec, write_out_dec, mul_done, in_valid, out_ready,
        output pc_en, reg_write, pc_rel_branch, mul_start, in_ack,
               out_valid, busy, err
    );

    // Environment side: decoder, multiplier and I/O ports.
    modport slave (
        output opcode, alu_func, reg_write_dec, pc_rel_branch_dec,
               read_in_dec, write_out_dec, mul_done, in_valid, out_ready,
        input  pc_en, reg_write, pc_rel_branch, mul_start, in_ack,
               out_valid, busy, err
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execution sequencer: passes single-cycle instructions straight through and
// stalls the PC for multiply / switch-input / output instructions until their
// handshake completes or a wait-state timeout aborts them (sticky err).
module exec_sequencer #(
    parameter int unsigned TIMEOUT = 64,      // 2..255 wait cycles before abort
    parameter logic [2:0]  RMLT    = 3'd3     // alu_func code of a multiply
) (
    input  logic          clk,
    input  logic          reset,
    exec_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, IN_WAIT, OUT_WAIT} state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_q, err_nxt;
    logic       timeout_hit;
    logic       pc_en, reg_write, pc_rel_branch, mul_start, in_ack, out_valid;

    // The opcode is only held for the decoder's benefit; nothing here decodes it.
    logic       unused_opcode;
    assign unused_opcode = ^bus.opcode;

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    // State, wait counter and sticky error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next-state and qualified control outputs.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        err_nxt       = err_q;
        pc_en         = 1'b0;
        reg_write     = 1'b0;
        pc_rel_branch = 1'b0;
        mul_start     = 1'b0;
        in_ack        = 1'b0;
        out_valid     = 1'b0;

        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (bus.alu_func == RMLT) begin
                    mul_start = 1'b1;
                    state_nxt = MUL_WAIT;
                end else if (bus.read_in_dec) begin
                    if (bus.in_valid) begin
                        in_ack    = 1'b1;
                        reg_write = 1'b1;
                        pc_en     = 1'b1;
                    end else begin
                        state_nxt = IN_WAIT;
                    end
                end else if (bus.write_out_dec) begin
                    out_valid = 1'b1;
                    if (bus.out_ready) pc_en = 1'b1;
                    else               state_nxt = OUT_WAIT;
                end else begin
                    pc_en         = 1'b1;
                    reg_write     = bus.reg_write_dec;
                    pc_rel_branch = bus.pc_rel_branch_dec;
                end
            end
            MUL_WAIT: begin
                if (bus.mul_done) begin
                    reg_write = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    pc_en     = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IN_WAIT: begin
                if (bus.in_valid) begin
                    in_ack    = 1'b1;
                    reg_write = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    pc_en     = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OUT_WAIT: begin
                if (bus.out_ready) begin
                    out_valid = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    pc_en     = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    out_valid = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // IDLE pass-through is combinational, so outputs must be forced low
        // while reset is held rather than relying on the state register.
        if (reset) begin
            pc_en         = 1'b0;
            reg_write     = 1'b0;
            pc_rel_branch = 1'b0;
            mul_start     = 1'b0;
            in_ack        = 1'b0;
            out_valid     = 1'b0;
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.reg_write     = reg_write;
    assign bus.pc_rel_branch = pc_rel_branch;
    assign bus.mul_start     = mul_start;
    assign bus.in_ack        = in_ack;
    assign bus.out_valid     = out_valid;
    assign bus.busy          = (state != IDLE);
    assign bus.err           = err_q;

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64, sets the maximum number of wait-state cycles before an instruction is aborted; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  opcode of the current instruction, held stable while pc_en=0.
REQ-005 alu_func  input  3  decoder ALU function; RMLT marks a multiply.
REQ-006 reg_write_dec / pc_rel_branch_dec / read_in_dec / write_out_dec  input  1 each  raw decoder controls.
REQ-007 mul_done  input  1  one-cycle pulse from the iterative multiplier; result valid.
REQ-008 in_valid  input  1  external switch input holds valid data.
REQ-009 out_ready  input  1  external output sink accepts data this cycle.
REQ-010 pc_en  output  1  advance the PC this cycle.
REQ-011 reg_write  output  1  qualified register-file write enable.
REQ-012 pc_rel_branch  output  1  qualified PC-relative branch.
REQ-013 mul_start  output  1  one-cycle pulse that launches the multiplier.
REQ-014 in_ack  output  1  input word consumed this cycle.
REQ-015 out_valid  output  1  output data on the bus is valid.
REQ-016 busy  output  1  high while the FSM is in any wait state.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have the states IDLE, MUL_WAIT, IN_WAIT and OUT_WAIT, plus an 8-bit wait_cnt and a sticky err register.
REQ-019 In IDLE, a non-wait instruction (not RMLT, not read_in_dec, not write_out_dec) SHALL pass through combinationally in the same cycle: pc_en=1, reg_write=reg_write_dec, pc_rel_branch=pc_rel_branch_dec.
REQ-020 In IDLE, an instruction with alu_func==RMLT SHALL:
- drive mul_start=1, pc_en=0 and reg_write=0 in that cycle;
- move to MUL_WAIT on the next edge.
REQ-021 In IDLE, an instruction with read_in_dec=1 and in_valid=1 SHALL complete in the same cycle with in_ack=1, reg_write=1 and pc_en=1; with in_valid=0 it SHALL drive pc_en=0 and move to IN_WAIT.
REQ-022 In IDLE, an instruction with write_out_dec=1 SHALL drive out_valid=1:
- out_ready=1 completes it in the same cycle with pc_en=1;
- otherwise pc_en=0 and the FSM moves to OUT_WAIT.
REQ-023 In MUL_WAIT, the cycle in which mul_done=1 SHALL drive reg_write=1 and pc_en=1, and the FSM SHALL return to IDLE.
REQ-024 In IN_WAIT, the cycle in which in_valid=1 SHALL drive in_ack=1, reg_write=1 and pc_en=1, and the FSM SHALL return to IDLE.
REQ-025 In OUT_WAIT, out_valid SHALL be held at 1; the cycle in which out_ready=1 SHALL drive pc_en=1, and the FSM SHALL return to IDLE.
REQ-026 In every wait state, pc_rel_branch and mul_start SHALL be 0, and pc_en/reg_write SHALL be 0 except in the completing cycle.
REQ-027 wait_cnt SHALL:
- clear to 0 on entry to a wait state;
- increment by 1 each wait cycle without completion;
- never wrap.
REQ-028 Timeout: when wait_cnt==TIMEOUT-1 and the completion condition is absent, the FSM SHALL drive pc_en=1 with reg_write=0, in_ack=0 and out_valid=0, set err=1, and return to IDLE.
REQ-029 When completion and timeout coincide in the same cycle, completion SHALL win and err SHALL be unchanged.
REQ-030 err SHALL remain 1 until reset.
REQ-031 busy SHALL equal (state != IDLE).
REQ-032 mul_done, in_valid and out_ready SHALL be ignored in any state not waiting on them.
REQ-033 Only one of the three wait conditions is ever present in a decoded instruction; if more than one is set, RMLT SHALL take priority, then read_in_dec, then write_out_dec.

Reset
REQ-034 While reset=1, the block SHALL immediately hold state=IDLE, wait_cnt=0 and err=0.
REQ-035 While reset=1, the outputs pc_en, reg_write, pc_rel_branch, mul_start, in_ack, out_valid and busy SHALL all be 0.
REQ-036 Reset in a wait state SHALL abandon the instruction with no register write; after reset release, the held opcode SHALL be re-evaluated from IDLE.

Verification
REQ-037 ADD, reg_write_dec=1 -> same cycle pc_en=1, reg_write=1, busy=0, mul_start=0.
REQ-038 MLT issued at cycle 0, mul_done at cycle 3 -> expected response:
- mul_start=1 only at cycle 0;
- pc_en=0 at cycles 0-2;
- busy=1 at cycles 1-3;
- reg_write=1 and pc_en=1 at cycle 3 only.
REQ-039 STIN with in_valid=1 -> single-cycle completion with in_ack=1, reg_write=1, pc_en=1; STIN with in_valid rising at cycle 5 -> stall at cycles 0-4, completion at cycle 5.
REQ-040 TIMEOUT=8, LOUT with out_ready=0 -> out_valid=1 for 8 cycles, then a timeout cycle with pc_en=1, reg_write=0, out_valid=0, and err=1 thereafter.
REQ-041 TIMEOUT=8, mul_done at the timeout cycle -> reg_write=1 and err stays 0; reset asserted mid-MUL_WAIT -> all outputs 0 immediately and no write occurs.
